// File: rtl/rsa_pkg.sv
// Shared FSM encoding and timing helper for the RSA modular-exponentiation engine.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE_M = 3'd1,
    PRE_A = 3'd2,
    SQR   = 3'd3,
    MUL   = 3'd4,
    POST  = 3'd5,
    DONE  = 3'd6
  } state_t;

  function automatic int mmm_cycles(input int width);
    return width + 32'sd2;
  endfunction

endpackage

// File: rtl/mont_mul_serial.sv
// Radix-2 bit-serial Montgomery multiplier: p = a*b*2^-WIDTH mod n.
// Fixed latency: 1 load cycle, WIDTH shift-add cycles, 1 final-subtract cycle.
module mont_mul_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             done
);

  localparam int STEPS = mmm_cycles(WIDTH) - 2;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int TW    = WIDTH + 2;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_p;
  logic [TW-1:0]    r_t;
  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic             r_sub;
  logic             r_done;

  logic [TW-1:0]    w_t_add;
  logic [TW-1:0]    w_t_odd;
  logic [TW-1:0]    w_t_nxt;
  logic             w_ge;
  logic [WIDTH-1:0] w_t_sub;

  // One shift-add step and the closing conditional subtract; T stays below 4N.
  always_comb begin
    w_t_add = r_t + (r_a[0] ? {2'b00, r_b} : {TW{1'b0}});
    w_t_odd = w_t_add[0] ? (w_t_add + {2'b00, r_n}) : w_t_add;
    w_t_nxt = w_t_odd >> 1'b1;
    w_ge    = (r_t >= {2'b00, r_n});
    w_t_sub = w_ge ? WIDTH'(r_t - {2'b00, r_n}) : r_t[WIDTH-1:0];
  end

  // Load / step / subtract sequencing; a new start always restarts the product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= {WIDTH{1'b0}};
      r_b    <= {WIDTH{1'b0}};
      r_n    <= {WIDTH{1'b0}};
      r_p    <= {WIDTH{1'b0}};
      r_t    <= {TW{1'b0}};
      r_cnt  <= {CW{1'b0}};
      r_run  <= 1'b0;
      r_sub  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_a   <= a;
        r_b   <= b;
        r_n   <= n;
        r_t   <= {TW{1'b0}};
        r_cnt <= {CW{1'b0}};
        r_run <= 1'b1;
        r_sub <= 1'b0;
      end else if (r_run) begin
        r_t   <= w_t_nxt;
        r_a   <= r_a >> 1'b1;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(STEPS - 1)) begin
          r_run <= 1'b0;
          r_sub <= 1'b1;
        end
      end else if (r_sub) begin
        r_p    <= w_t_sub;
        r_done <= 1'b1;
        r_sub  <= 1'b0;
      end
    end
  end

  assign p    = r_p;
  assign done = r_done;

endmodule

// File: rtl/rsa_modexp_core.sv
// RSA engine: result = M^E mod N by left-to-right square-and-multiply over one
// shared Montgomery multiplier; operands enter/leave Montgomery form internally.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit CONST_TIME = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] m_in,
  input  logic [WIDTH-1:0] e_in,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] r2_in,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int               BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]    LAST_IDX = BW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_r2;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_mb;
  logic [WIDTH-1:0] r_result;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_launch;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_mm_start;
  logic [WIDTH-1:0] w_mm_a;
  logic [WIDTH-1:0] w_mm_b;
  logic [WIDTH-1:0] w_mm_p;
  logic             w_mm_done;

  logic             w_accept;
  logic             w_e_bit;
  logic             w_last_bit;
  logic             w_even_n;
  logic             w_mul_needed;
  logic [WIDTH-1:0] w_a_eff;
  logic             w_a_load;
  logic             w_mb_load;
  logic             w_e_shift;
  logic             w_res_load;

  assign w_accept     = (r_state == IDLE) && start;
  assign w_e_bit      = r_e[WIDTH-1];
  assign w_last_bit   = (r_bit_cnt == {BW{1'b0}});
  assign w_even_n     = ~r_n[0];
  assign w_mul_needed = w_e_bit | CONST_TIME;

  mont_mul_serial #(.WIDTH(WIDTH)) u_mmm (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_mm_start),
    .a     (w_mm_a),
    .b     (w_mm_b),
    .n     (r_n),
    .p     (w_mm_p),
    .done  (w_mm_done)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: every step waits for the multiplier's done pulse.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = start ? PRE_M : IDLE;
      PRE_M: begin
        if (w_even_n)       w_next_state = DONE;
        else if (w_mm_done) w_next_state = PRE_A;
        else                w_next_state = PRE_M;
      end
      PRE_A:   w_next_state = w_mm_done ? SQR : PRE_A;
      SQR: begin
        if (!w_mm_done)       w_next_state = SQR;
        else if (w_mul_needed) w_next_state = MUL;
        else if (w_last_bit)   w_next_state = POST;
        else                   w_next_state = SQR;
      end
      MUL: begin
        if (!w_mm_done)      w_next_state = MUL;
        else if (w_last_bit) w_next_state = POST;
        else                 w_next_state = SQR;
      end
      POST:    w_next_state = w_mm_done ? DONE : POST;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: the next product issues in the same cycle the previous one
  // completes, so its operands are forwarded from the multiplier output.
  always_comb begin
    w_mm_start = 1'b0;
    w_mm_a     = r_a;
    w_mm_b     = r_a;
    w_a_eff    = r_a;
    w_a_load   = 1'b0;
    w_mb_load  = 1'b0;
    w_e_shift  = 1'b0;
    w_res_load = 1'b0;
    case (r_state)
      PRE_M: begin
        if (r_launch) begin
          w_mm_start = ~w_even_n;
          w_mm_a     = r_m;
          w_mm_b     = r_r2;
        end else if (w_mm_done) begin
          w_mb_load  = 1'b1;
          w_mm_start = 1'b1;
          w_mm_a     = ONE;
          w_mm_b     = r_r2;
        end else begin
          w_mm_start = 1'b0;
        end
      end
      PRE_A: begin
        w_a_eff  = w_mm_p;
        w_mm_a   = w_a_eff;
        w_mm_b   = w_a_eff;
        w_a_load = w_mm_done;
        w_mm_start = w_mm_done;
      end
      SQR: begin
        w_a_eff    = w_mm_p;
        w_mm_a     = w_a_eff;
        w_a_load   = w_mm_done;
        w_mm_start = w_mm_done;
        if (w_mul_needed) begin
          w_mm_b = r_mb;
        end else if (w_last_bit) begin
          w_mm_b = ONE;
        end else begin
          w_mm_b    = w_a_eff;
          w_e_shift = w_mm_done;
        end
      end
      MUL: begin
        // A zero bit in constant-time mode throws the product away.
        w_a_eff    = w_e_bit ? w_mm_p : r_a;
        w_mm_a     = w_a_eff;
        w_a_load   = w_mm_done & w_e_bit;
        w_mm_start = w_mm_done;
        if (w_last_bit) begin
          w_mm_b = ONE;
        end else begin
          w_mm_b    = w_a_eff;
          w_e_shift = w_mm_done;
        end
      end
      POST:    w_res_load = w_mm_done;
      default: w_mm_start = 1'b0;
    endcase
  end

  // Operand latch, Montgomery accumulators and exponent scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m       <= {WIDTH{1'b0}};
      r_e       <= {WIDTH{1'b0}};
      r_n       <= {WIDTH{1'b0}};
      r_r2      <= {WIDTH{1'b0}};
      r_a       <= {WIDTH{1'b0}};
      r_mb      <= {WIDTH{1'b0}};
      r_bit_cnt <= {BW{1'b0}};
      r_launch  <= 1'b0;
    end else if (w_accept) begin
      r_m       <= m_in;
      r_e       <= e_in;
      r_n       <= n_in;
      r_r2      <= r2_in;
      r_a       <= {WIDTH{1'b0}};
      r_mb      <= {WIDTH{1'b0}};
      r_bit_cnt <= LAST_IDX;
      r_launch  <= 1'b1;
    end else begin
      r_launch <= 1'b0;
      if (w_mb_load) r_mb <= w_mm_p;
      if (w_a_load)  r_a  <= w_mm_p;
      if (w_e_shift) begin
        r_e       <= r_e << 1'b1;
        r_bit_cnt <= r_bit_cnt - BW'(1);
      end
    end
  end

  // Registered status and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= {WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_busy   <= 1'b1;
        r_err    <= 1'b0;
        r_result <= {WIDTH{1'b0}};
      end else if ((r_state == PRE_M) && w_even_n) begin
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
        r_err    <= 1'b1;
        r_result <= {WIDTH{1'b0}};
      end else if (w_res_load) begin
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
        r_result <= w_mm_p;
      end
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Self-checking bench for rsa_modexp_core: directed RSA vectors, boundaries,
// protocol corner cases and randomised operands against a plain-arithmetic model.
module tb_rsa_modexp_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] m_v [4];
  logic [31:0] e_v [4];
  logic [31:0] n_v [4];
  logic [31:0] r2_v[4];
  logic [3:0]  st_v;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  err_v;
  logic [7:0]  res0, res1;
  logic [15:0] res2;
  logic [31:0] res3;

  int n_vec;
  int n_err;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
    logic [31:0] cyc;
    logic        b_start;
    logic        b_done;
    logic        tail;
  } obs_t;

  rsa_modexp_core #(.WIDTH(8), .CONST_TIME(1'b0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(st_v[0]), .m_in(m_v[0][7:0]), .e_in(e_v[0][7:0]),
    .n_in(n_v[0][7:0]), .r2_in(r2_v[0][7:0]), .result(res0), .busy(busy_v[0]),
    .done(done_v[0]), .err(err_v[0]));

  rsa_modexp_core #(.WIDTH(8), .CONST_TIME(1'b1)) u_w8_ct (
    .clk(clk), .rst_n(rst_n), .start(st_v[1]), .m_in(m_v[1][7:0]), .e_in(e_v[1][7:0]),
    .n_in(n_v[1][7:0]), .r2_in(r2_v[1][7:0]), .result(res1), .busy(busy_v[1]),
    .done(done_v[1]), .err(err_v[1]));

  rsa_modexp_core #(.WIDTH(16), .CONST_TIME(1'b0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(st_v[2]), .m_in(m_v[2][15:0]), .e_in(e_v[2][15:0]),
    .n_in(n_v[2][15:0]), .r2_in(r2_v[2][15:0]), .result(res2), .busy(busy_v[2]),
    .done(done_v[2]), .err(err_v[2]));

  rsa_modexp_core #(.WIDTH(32), .CONST_TIME(1'b0)) u_w32 (
    .clk(clk), .rst_n(rst_n), .start(st_v[3]), .m_in(m_v[3]), .e_in(e_v[3]),
    .n_in(n_v[3]), .r2_in(r2_v[3]), .result(res3), .busy(busy_v[3]),
    .done(done_v[3]), .err(err_v[3]));

  function automatic int wid(input int k);
    case (k)
      2:       return 16;
      3:       return 32;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int k);
    case (k)
      0:       return {24'd0, res0};
      1:       return {24'd0, res1};
      2:       return {16'd0, res2};
      default: return res3;
    endcase
  endfunction

  // Reference: ordinary right-to-left modular exponentiation.
  function automatic logic [63:0] ref_modexp(input logic [63:0] m, e, n, input int w);
    logic [63:0] acc, base;
    acc  = 64'd1 % n;
    base = m % n;
    for (int i = 0; i < w; i++) begin
      if (e[i]) acc = (acc * base) % n;
      base = (base * base) % n;
    end
    return acc;
  endfunction

  function automatic logic [63:0] ref_r2(input logic [63:0] n, input int w);
    logic [63:0] acc;
    acc = 64'd1 % n;
    for (int i = 0; i < 2 * w; i++) acc = (acc << 1) % n;
    return acc;
  endfunction

  function automatic int exp_cycles(input logic [31:0] e, input int w, input bit ct);
    int ops;
    ops = ct ? (3 + 2 * w) : (3 + w + $countones(e & ((w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1))));
    return ops * (w + 2) + 1;
  endfunction

  task automatic run_op(input int k, input logic [31:0] m, e, n, r2, output obs_t o);
    int cyc;
    @(negedge clk);
    m_v[k] = m; e_v[k] = e; n_v[k] = n; r2_v[k] = r2; st_v[k] = 1'b1;
    @(posedge clk); #1;
    st_v[k] = 1'b0;
    o.b_start = busy_v[k];
    m_v[k] = $urandom; e_v[k] = $urandom; n_v[k] = $urandom; r2_v[k] = $urandom;
    cyc = 0;
    while (done_v[k] !== 1'b1 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    o.cyc    = cyc;
    o.res    = get_res(k);
    o.err    = err_v[k];
    o.b_done = busy_v[k];
    @(posedge clk); #1;
    o.tail = done_v[k];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy_v, done_v, err_v} !== 12'd0) begin
      n_err++;
      $display("FAIL reset flags: got busy=%b done=%b err=%b expected all 0", busy_v, done_v, err_v);
    end
    n_vec++;
    if ({res0, res1, res2, res3} !== 64'd0) begin
      n_err++;
      $display("FAIL reset result: got %h %h %h %h expected 0", res0, res1, res2, res3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_encrypt();
    obs_t o;
    run_op(0, 32'd88, 32'd7, 32'd187, 32'd86, o);
    n_vec++;
    if (o.res !== 32'd11) begin n_err++; $display("FAIL encrypt result: got %0d expected 11", o.res); end
    n_vec++;
    if (o.err !== 1'b0) begin n_err++; $display("FAIL encrypt err: got %b expected 0", o.err); end
    n_vec++;
    if (o.cyc !== 32'd141) begin n_err++; $display("FAIL encrypt latency: got %0d expected 141", o.cyc); end
    n_vec++;
    if ({o.b_start, o.b_done, o.tail} !== 3'b100) begin
      n_err++;
      $display("FAIL encrypt busy/done shape: got busy_start=%b busy_done=%b done_next=%b expected 1 0 0",
               o.b_start, o.b_done, o.tail);
    end
  endtask

  task automatic test_decrypt();
    obs_t o;
    run_op(0, 32'd11, 32'd23, 32'd187, 32'd86, o);
    n_vec++;
    if (o.res !== 32'd88 || o.cyc !== 32'(exp_cycles(32'd23, 8, 1'b0))) begin
      n_err++;
      $display("FAIL decrypt: got result=%0d cycles=%0d expected 88 and %0d", o.res, o.cyc, exp_cycles(32'd23, 8, 1'b0));
    end
    run_op(1, 32'd11, 32'd23, 32'd187, 32'd86, o);
    n_vec++;
    if (o.res !== 32'd88 || o.cyc !== 32'd191) begin
      n_err++;
      $display("FAIL decrypt ct E=23: got result=%0d cycles=%0d expected 88 and 191", o.res, o.cyc);
    end
    run_op(1, 32'd88, 32'd7, 32'd187, 32'd86, o);
    n_vec++;
    if (o.res !== 32'd11 || o.cyc !== 32'd191) begin
      n_err++;
      $display("FAIL encrypt ct E=7: got result=%0d cycles=%0d expected 11 and 191", o.res, o.cyc);
    end
  endtask

  task automatic test_boundaries();
    obs_t o;
    int unsigned tk[5] = '{0, 0, 0, 1, 1};
    logic [31:0] tm[5] = '{32'd88, 32'd0, 32'd0, 32'd88, 32'd0};
    logic [31:0] te[5] = '{32'd0, 32'd5, 32'd9, 32'd0, 32'd3};
    logic [31:0] tn[5] = '{32'd187, 32'd187, 32'd1, 32'd187, 32'd1};
    logic [31:0] tr[5] = '{32'd86, 32'd86, 32'd0, 32'd86, 32'd0};
    logic [31:0] tx[5] = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd0};
    for (int i = 0; i < 5; i++) begin
      run_op(int'(tk[i]), tm[i], te[i], tn[i], tr[i], o);
      n_vec++;
      if (o.res !== tx[i] || o.cyc !== 32'(exp_cycles(te[i], 8, tk[i] == 1))) begin
        n_err++;
        $display("FAIL boundary %0d: got result=%0d cycles=%0d expected %0d and %0d",
                 i, o.res, o.cyc, tx[i], exp_cycles(te[i], 8, tk[i] == 1));
      end
    end
  endtask

  task automatic test_even_n();
    obs_t o;
    run_op(0, 32'd88, 32'd7, 32'd186, 32'd86, o);
    n_vec++;
    if (o.cyc !== 32'd1 || o.err !== 1'b1 || o.res !== 32'd0 || o.tail !== 1'b0) begin
      n_err++;
      $display("FAIL even-N: got cycles=%0d err=%b result=%0d done_next=%b expected 1 1 0 0",
               o.cyc, o.err, o.res, o.tail);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (err_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL even-N hold: got err=%b done=%b expected 1 0", err_v[0], done_v[0]);
    end
    run_op(0, 32'd88, 32'd7, 32'd187, 32'd86, o);
    n_vec++;
    if (o.err !== 1'b0 || o.res !== 32'd11) begin
      n_err++;
      $display("FAIL even-N recovery: got err=%b result=%0d expected 0 and 11", o.err, o.res);
    end
  endtask

  task automatic test_busy_start();
    int cyc;
    @(negedge clk);
    m_v[0] = 32'd88; e_v[0] = 32'd7; n_v[0] = 32'd187; r2_v[0] = 32'd86; st_v[0] = 1'b1;
    @(posedge clk); #1;
    st_v[0] = 1'b0;
    cyc = 0;
    repeat (30) begin @(posedge clk); #1; cyc++; end
    @(negedge clk);
    m_v[0] = 32'd5; e_v[0] = 32'd3; st_v[0] = 1'b1;
    @(posedge clk); #1;
    st_v[0] = 1'b0;
    cyc++;
    while (done_v[0] !== 1'b1 && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    n_vec++;
    if (res0 !== 8'd11 || cyc !== 141) begin
      n_err++;
      $display("FAIL start-while-busy: got result=%0d cycles=%0d expected 11 and 141", res0, cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int seen;
    run_op(1, 32'd88, 32'd7, 32'd186, 32'd86, o);
    @(negedge clk);
    m_v[0] = 32'd88; e_v[0] = 32'd7; n_v[0] = 32'd187; r2_v[0] = 32'd86; st_v[0] = 1'b1;
    @(posedge clk); #1;
    st_v[0] = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || err_v[1] !== 1'b0 || res0 !== 8'd0 || res1 !== 8'd0) begin
      n_err++;
      $display("FAIL mid-op reset: got busy=%b done=%b err1=%b res0=%0d res1=%0d expected all 0",
               busy_v[0], done_v[0], err_v[1], res0, res1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (150) begin @(posedge clk); #1; if (done_v[0] === 1'b1) seen++; end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL reset abort: got %0d stray done pulses expected 0", seen); end
    run_op(0, 32'd11, 32'd23, 32'd187, 32'd86, o);
    n_vec++;
    if (o.res !== 32'd88 || o.cyc !== 32'd151) begin
      n_err++;
      $display("FAIL post-reset op: got result=%0d cycles=%0d expected 88 and 151", o.res, o.cyc);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    run_op(0, 32'd88, 32'd7, 32'd187, 32'd86, o1);
    run_op(0, 32'd11, 32'd23, 32'd187, 32'd86, o2);
    n_vec++;
    if (o1.res !== 32'd11 || o2.res !== 32'd88 || o2.cyc !== 32'd151) begin
      n_err++;
      $display("FAIL back-to-back: got %0d,%0d cycles=%0d expected 11,88 and 151", o1.res, o2.res, o2.cyc);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int w;
    logic [31:0] mask, n, m, e, r2, exp_res;
    for (int k = 0; k < 4; k++) begin
      w    = wid(k);
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      for (int it = 0; it < ((k == 3) ? 4 : 6); it++) begin
        n       = ($urandom & mask) | (32'd1 << (w - 1)) | 32'd1;
        m       = $urandom % n;
        e       = $urandom & mask;
        r2      = 32'(ref_r2({32'd0, n}, w));
        exp_res = 32'(ref_modexp({32'd0, m}, {32'd0, e}, {32'd0, n}, w));
        run_op(k, m, e, n, r2, o);
        n_vec++;
        if (o.res !== exp_res || o.err !== 1'b0) begin
          n_err++;
          $display("FAIL random w%0d result: M=%0d E=%0d N=%0d got %0d err=%b expected %0d",
                   w, m, e, n, o.res, o.err, exp_res);
        end
        n_vec++;
        if (o.cyc !== 32'(exp_cycles(e, w, k == 1))) begin
          n_err++;
          $display("FAIL random w%0d latency: E=%0d got %0d expected %0d", w, e, o.cyc, exp_cycles(e, w, k == 1));
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    st_v  = 4'd0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 32'd0; e_v[i] = 32'd0; n_v[i] = 32'd0; r2_v[i] = 32'd0;
    end
    test_reset();
    test_encrypt();
    test_decrypt();
    test_boundaries();
    test_even_n();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_core.md
# rsa_modexp_core

Parametrised RSA modular-exponentiation engine computing `result = M^E mod N` by left-to-right square-and-multiply over a bit-serial Montgomery multiplier. It sits behind the register bank of `tt_um_calonso88_rsa`:

- The host supplies operands and the precomputed constant `R2 = 2^(2*WIDTH) mod N`.
- The engine handles Montgomery entry/exit internally.
- It generalises the fixed 8-bit engine to any `WIDTH` and adds a constant-time mode.

## Interface

Parameters:

- `WIDTH`, default 8: operand width in bits; Montgomery radix `R = 2^WIDTH`.
- `CONST_TIME`, default 0:
  - 1: a multiply is performed for every exponent bit, and its result is discarded when the bit is 0.
  - 0: the multiply is skipped when the bit is 0.

Ports:

- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `m_in`  in  WIDTH  base M; must satisfy M < N.
- `e_in`  in  WIDTH  exponent E.
- `n_in`  in  WIDTH  modulus N; must be odd.
- `r2_in`  in  WIDTH  `R^2 mod N`.
- `result`  out  WIDTH  `M^E mod N`; held until the next accepted start.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `done`  out  1  one-cycle pulse when `result` and `err` are valid.
- `err`  out  1  set when the accepted N was even; held until the next accepted start.

## Operation

- **Accept:** in IDLE with `start=1`:
  - latch all four operands;
  - clear `err` and `result`;
  - the inputs may change afterwards without effect.
- **Even-N check:** if the latched N[0]=0, go to DONE:
  - `err=1`, `result=0`;
  - no multiplications are performed.
- **FSM states and transitions:**
  - IDLE → PRE_M: `Mb = MMM(M, R2)`.
  - PRE_M → PRE_A: `A = MMM(1, R2)`.
  - Exponent scan, bit index i from WIDTH-1 down to 0:
    - SQR: `A = MMM(A, A)`.
    - If E[i]=1, MUL: `A = MMM(A, Mb)`.
    - If E[i]=0 and CONST_TIME=1, MUL: compute `T = MMM(A, Mb)` and discard T.
  - After bit 0, POST: `result = MMM(A, 1)`.
  - POST → DONE → IDLE.
- **Leading zeros:** all WIDTH exponent bits are scanned; leading zeros are not skipped.
- **MMM (Montgomery product):**
  - Computes `a*b*R^-1 mod N`, radix-2, bit-serial over a[0..WIDTH-1].
  - Per step: `T += a_i*B`; if T is odd, `T += N`; then `T >>= 1`.
  - After the loop, one conditional subtract: if T ≥ N, `T -= N`.
  - The T register is WIDTH+2 bits wide; inputs < N guarantee T < 2N before the subtract.
- **Boundary values:**
  - E=0 → result = `1 mod N` (0 when N=1).
  - M=0 → 0 for E>0.
  - M ≥ N and `r2_in ≠ R^2 mod N` are host errors; they are not checked and the result is undefined.
- **`start` while busy:** ignored; it is not queued.
- **Reset, at any point including mid-operation:**
  - next state IDLE;
  - `busy=0`, `done=0`, `err=0`, `result=0`;
  - the MMM datapath is cleared.

## Timing

- Each MMM operation costs exactly WIDTH+2 cycles: 1 load/issue, WIDTH shift-add steps, 1 final subtract.
- Number of operations K:
  - CONST_TIME=0: `K = 3 + WIDTH + popcount(E)`.
  - CONST_TIME=1: `K = 3 + 2*WIDTH`; latency is independent of E.
- `done` pulses exactly `K*(WIDTH+2)+1` cycles after the cycle where `start` is sampled.
- `busy` falls in the same cycle `done` rises.
- `result` and `err` update in the `done` cycle and hold afterwards.
- Even-N path: `done` and `err` assert 1 cycle after `start` is sampled.
- Back-to-back operation: `start` may be reasserted in the cycle after `done`.
- All outputs are registered.

## Structure

- Package `rsa_pkg`:
  - FSM state enum (IDLE, PRE_M, PRE_A, SQR, MUL, POST, DONE);
  - helper function `mmm_cycles(WIDTH) = WIDTH+2`.
- Sub-module `mont_mul_serial #(WIDTH)`:
  - ports: `clk`, `rst_n`, `start`, `a`, `b`, `n`, `p`, `done`;
  - fixed WIDTH+2 latency;
  - instantiated once in `rsa_modexp_core`.
- The top-level controller owns the exponent shift register, the bit counter, the A/Mb registers and the discard mux.

## Test plan

Scenarios 1–4 use WIDTH=8.

1. **Encrypt:** CONST_TIME=0, N=187, R2=86, M=88, E=7 → result=11, err=0, `done` at cycle 141 after start (K=14).
2. **Decrypt:** N=187, R2=86, M=11, E=23 → result=88. Repeat with CONST_TIME=1 → result=88 and `done` at cycle 191 for both E=7 and E=23.
3. **Boundaries:**
   - E=0, M=88, N=187 → result=1.
   - M=0, E=5 → result=0.
   - N=1, R2=0 → result=0.
4. **Even modulus:** N=186 → `done` and `err=1` one cycle after start, result=0; the next valid start clears `err`.
5. **Busy and reset:**
   - `start` pulsed mid-operation → ignored; the original result is unchanged.
   - `rst_n` low for 1 cycle mid-operation → all outputs 0 and FSM in IDLE; a new start then completes correctly.
6. **Randomised, WIDTH=16 and 32:** odd N with bit WIDTH-1 set, random M < N, random E, host-computed R2 → result matches the reference model and cycle count matches the formula.
